// File: rtl/move_pulse_gen.sv
// rtl/move_pulse_gen.sv - synchronised, chord-rejecting one-cycle move pulses from active-low buttons
// Optional auto-repeat is compiled in with `define MOVE_AUTOREPEAT_EN.
module move_pulse_gen #(
  parameter int REPEAT_DELAY = 24,
  parameter int REPEAT_RATE  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_n,
  input  logic       freeze,
  output logic       L,
  output logic       R,
  output logic       U,
  output logic       D
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [3:0] sync1, sync2;
  logic [3:0] pressed;
  logic [3:0] dir, dir_nx;
  logic [3:0] pulse, pulse_nx;
  logic       one_hot, multi, other_key;

  assign pressed   = ~sync2;
  assign one_hot   = $onehot(pressed);
  assign multi     = (pressed != '0) && !one_hot;
  assign other_key = |(pressed & ~dir);

  // Bit order of pulse matches key_n: {left, up, down, right}
  assign L = pulse[3];
  assign U = pulse[2];
  assign D = pulse[1];
  assign R = pulse[0];

`ifdef MOVE_AUTOREPEAT_EN
  localparam int MAX_PERIOD = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW         = $clog2(MAX_PERIOD);

  logic [CW-1:0] cnt, cnt_nx;
  logic          repeating, repeating_nx;
  logic          expire;

  // First repeat waits REPEAT_DELAY, later ones REPEAT_RATE
  assign expire = (cnt == (repeating ? CW'(REPEAT_RATE - 1) : CW'(REPEAT_DELAY - 1)));
`else
  logic unused_params;
  assign unused_params = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    pulse_nx = '0;
`ifdef MOVE_AUTOREPEAT_EN
    cnt_nx       = '0;
    repeating_nx = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (freeze) begin
          state_nx = LOCK;
        end else if (one_hot) begin
          pulse_nx = pressed;
          dir_nx   = pressed;
          state_nx = HELD;
        end else if (multi) begin
          state_nx = LOCK;
        end
      end
      HELD: begin
        if (pressed == '0) begin
          state_nx = IDLE;
        end else if (freeze || other_key) begin
          state_nx = LOCK;
        end else begin
`ifdef MOVE_AUTOREPEAT_EN
          if (expire) begin
            pulse_nx     = dir;
            repeating_nx = 1'b1;
          end else begin
            cnt_nx       = cnt + CW'(1);
            repeating_nx = repeating;
          end
`endif
        end
      end
      LOCK: begin
        if ((pressed == '0) && !freeze) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
      state <= IDLE;
      dir   <= '0;
      pulse <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      state <= state_nx;
      dir   <= dir_nx;
      pulse <= pulse_nx;
    end
  end

`ifdef MOVE_AUTOREPEAT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      repeating <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      repeating <= repeating_nx;
    end
  end
`endif

endmodule

// File: tb/tb_move_pulse_gen.sv
// tb/tb_move_pulse_gen.sv - directed self-checking bench for move_pulse_gen
module tb_move_pulse_gen;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] key_n;
  logic       freeze;
  logic       L, R, U, D;

  int pass_cnt  = 0;
  int check_cnt = 0;

  move_pulse_gen dut (
    .clock (clock),
    .reset (reset),
    .key_n (key_n),
    .freeze(freeze),
    .L     (L),
    .R     (R),
    .U     (U),
    .D     (D)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] outs();
    return {L, U, D, R};
  endfunction

  task automatic test_reset();
    reset  = 1'b1;
    key_n  = 4'hF;
    freeze = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      check_cnt++;
      if (outs() !== 4'b0000) $display("FAIL reset_outs cycle %0d: got %b want 0000", i, outs());
      else pass_cnt++;
    end
    check_cnt++;
    if (dut.state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dut.state);
    else pass_cnt++;
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_cnt++;
      if (outs() !== 4'b0000) $display("FAIL idle_outs cycle %0d: got %b want 0000", i, outs());
      else pass_cnt++;
    end
  endtask

  task automatic test_single_left();
    key_n = 4'b0111;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_cnt++;
      if (outs() !== ((i == 3) ? 4'b1000 : 4'b0000))
        $display("FAIL left_hold cycle %0d: got %b want %b", i, outs(), (i == 3) ? 4'b1000 : 4'b0000);
      else pass_cnt++;
    end
    key_n = 4'hF;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_cnt++;
      if (outs() !== 4'b0000) $display("FAIL left_release cycle %0d: got %b want 0000", i, outs());
      else pass_cnt++;
    end
  endtask

  task automatic test_chord();
    key_n = 4'b0110;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_cnt++;
      if (outs() !== 4'b0000) $display("FAIL chord cycle %0d: got %b want 0000", i, outs());
      else pass_cnt++;
    end
    key_n = 4'b1110;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_cnt++;
      if (outs() !== 4'b0000) $display("FAIL chord_partial cycle %0d: got %b want 0000", i, outs());
      else pass_cnt++;
    end
    key_n = 4'hF;
    for (int i = 1; i <= 4; i++) tick();
    check_cnt++;
    if (dut.state !== 2'd0) $display("FAIL chord_unlock: got state %0d want 0", dut.state);
    else pass_cnt++;
    key_n = 4'b1110;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_cnt++;
      if (outs() !== ((i == 3) ? 4'b0001 : 4'b0000))
        $display("FAIL right_after_chord cycle %0d: got %b want %b", i, outs(), (i == 3) ? 4'b0001 : 4'b0000);
      else pass_cnt++;
    end
    key_n = 4'hF;
    for (int i = 1; i <= 4; i++) tick();
  endtask

  task automatic test_freeze();
    key_n = 4'b1011;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_cnt++;
      if (outs() !== ((i == 3) ? 4'b0100 : 4'b0000))
        $display("FAIL up_press cycle %0d: got %b want %b", i, outs(), (i == 3) ? 4'b0100 : 4'b0000);
      else pass_cnt++;
    end
    freeze = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_cnt++;
      if (outs() !== 4'b0000) $display("FAIL frozen cycle %0d: got %b want 0000", i, outs());
      else pass_cnt++;
    end
    freeze = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_cnt++;
      if (outs() !== 4'b0000) $display("FAIL held_after_freeze cycle %0d: got %b want 0000", i, outs());
      else pass_cnt++;
    end
    key_n = 4'hF;
    for (int i = 1; i <= 4; i++) tick();
    key_n = 4'b1011;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_cnt++;
      if (outs() !== ((i == 3) ? 4'b0100 : 4'b0000))
        $display("FAIL up_repress cycle %0d: got %b want %b", i, outs(), (i == 3) ? 4'b0100 : 4'b0000);
      else pass_cnt++;
    end
    key_n = 4'hF;
    for (int i = 1; i <= 4; i++) tick();
  endtask

  task automatic test_long_hold();
    logic [3:0] exp;
    key_n = 4'b1101;
    for (int i = 1; i <= 53; i++) begin
      tick();
`ifdef MOVE_AUTOREPEAT_EN
      exp = (i == 3 || i == 27 || i == 35 || i == 43 || i == 51) ? 4'b0010 : 4'b0000;
`else
      exp = (i == 3) ? 4'b0010 : 4'b0000;
`endif
      check_cnt++;
      if (outs() !== exp) $display("FAIL down_hold cycle %0d: got %b want %b", i, outs(), exp);
      else pass_cnt++;
    end
    key_n = 4'hF;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_cnt++;
      if (outs() !== 4'b0000) $display("FAIL down_release cycle %0d: got %b want 0000", i, outs());
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_press();
    key_n = 4'b1110;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_cnt++;
      if (outs() !== ((i == 3) ? 4'b0001 : 4'b0000))
        $display("FAIL right_before_reset cycle %0d: got %b want %b", i, outs(), (i == 3) ? 4'b0001 : 4'b0000);
      else pass_cnt++;
    end
    reset = 1'b1;
    tick();
    check_cnt++;
    if (outs() !== 4'b0000) $display("FAIL outs_in_reset: got %b want 0000", outs());
    else pass_cnt++;
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_cnt++;
      if (outs() !== ((i == 3) ? 4'b0001 : 4'b0000))
        $display("FAIL right_after_reset cycle %0d: got %b want %b", i, outs(), (i == 3) ? 4'b0001 : 4'b0000);
      else pass_cnt++;
    end
    key_n = 4'hF;
    for (int i = 1; i <= 4; i++) tick();
  endtask

  initial begin
    test_reset();
    test_single_left();
    test_chord();
    test_freeze();
    test_long_hold();
    test_reset_mid_press();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
